// File: rtl/stage_idecode_rle_if.sv
// Fetch-side and execute-side handshake bundle for the run-length-coalescing decode stage.
// The slave modport is the decode stage; the master modport is whoever drives fetch bytes and takes outputs.
interface stage_idecode_rle_if #(
    parameter int COUNT_WIDTH = 8
);
    logic [7:0]             opcode_in;
    logic                   drdy_in;
    logic                   ack;
    logic [7:0]             operation;
    logic [COUNT_WIDTH-1:0] count;
    logic                   drdy;
    logic                   ack_in;

    modport master (
        output opcode_in, drdy_in, ack_in,
        input  ack, operation, count, drdy
    );

    modport slave (
        input  opcode_in, drdy_in, ack_in,
        output ack, operation, count, drdy
    );
endinterface

// File: rtl/stage_idecode_rle.sv
// Brainfuck decode stage: drops comment bytes, emits one-hot ops and merges runs of > < + - into one op with a count.
// Build option IDECODE_COALESCE_EN: defined = runs are merged; undefined = every command is emitted with count=1.
module stage_idecode_rle #(
    parameter int COUNT_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    stage_idecode_rle_if.slave bus,
    output logic [1:0]         o_dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [7:0]             r_op;
    logic [7:0]             w_op_nxt;
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic [COUNT_WIDTH-1:0] w_cnt_nxt;
    logic                   r_ack;
    logic                   w_ack_nxt;
    logic                   r_drdy;
    logic [7:0]             r_operation;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [7:0]             w_byte_op;
    logic                   w_is_cmd;
    logic                   w_take;
`ifdef IDECODE_COALESCE_EN
    logic                   w_is_run;
`endif

    function automatic logic [7:0] decode_op(input logic [7:0] b);
        logic [7:0] op;
        op = '0;
        case (b)
            8'h3E:   op = 8'h01;
            8'h3C:   op = 8'h02;
            8'h2B:   op = 8'h04;
            8'h2D:   op = 8'h08;
            8'h2E:   op = 8'h10;
            8'h2C:   op = 8'h20;
            8'h5B:   op = 8'h40;
            8'h5D:   op = 8'h80;
            default: op = 8'h00;
        endcase
        return op;
    endfunction

    // Handshake: fetch holds opcode_in while drdy_in=1 and advances on the one-cycle registered ack pulse;
    // the cycle carrying ack is a bubble in which inputs are ignored. Output side: operation/count are held
    // with drdy=1 until ack_in is sampled high, after which drdy drops the next cycle.
    assign w_byte_op = decode_op(bus.opcode_in);
    assign w_is_cmd  = |w_byte_op;
    assign w_take    = bus.drdy_in && !r_ack;
`ifdef IDECODE_COALESCE_EN
    assign w_is_run  = |w_byte_op[3:0];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_cnt_nxt   = r_cnt;
        w_ack_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_ack_nxt = 1'b1;
                    if (w_is_cmd) begin
                        w_op_nxt  = w_byte_op;
                        w_cnt_nxt = CNT_ONE;
`ifdef IDECODE_COALESCE_EN
                        w_state_nxt = w_is_run ? ACC : EMIT;
`else
                        w_state_nxt = EMIT;
`endif
                    end
                end
            end
            ACC: begin
                // Comment bytes are swallowed inside a run; anything that cannot extend it is left for IDLE.
                if (!r_ack) begin
                    if (!bus.drdy_in) begin
                        w_state_nxt = EMIT;
                    end else if (!w_is_cmd) begin
                        w_ack_nxt = 1'b1;
                    end else if ((w_byte_op == r_op) && (r_cnt != CNT_MAX)) begin
                        w_ack_nxt = 1'b1;
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end else begin
                        w_state_nxt = EMIT;
                    end
                end
            end
            EMIT: begin
                if (bus.ack_in) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_cnt       <= '0;
            r_ack       <= 1'b0;
            r_drdy      <= 1'b0;
            r_operation <= '0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ack       <= w_ack_nxt;
            r_drdy      <= (w_state_nxt == EMIT);
            r_operation <= (w_state_nxt == EMIT) ? w_op_nxt : '0;
            r_count     <= (w_state_nxt == EMIT) ? w_cnt_nxt : '0;
        end
    end

    assign bus.ack       = r_ack;
    assign bus.drdy      = r_drdy;
    assign bus.operation = r_operation;
    assign bus.count     = r_count;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_stage_idecode_rle.sv
// Self-checking bench for stage_idecode_rle: two instances (COUNT_WIDTH 8 and 2) against a run-grouping model.
// The model follows IDECODE_COALESCE_EN the same way the design build does.
module tb_stage_idecode_rle;
`ifdef IDECODE_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] dbg8;
  logic [1:0] dbg2;

  // clock/reset block
  always #5 clk = ~clk;

  stage_idecode_rle_if #(.COUNT_WIDTH(8)) bus8();
  stage_idecode_rle_if #(.COUNT_WIDTH(2)) bus2();

  stage_idecode_rle #(.COUNT_WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8), .o_dbg_state(dbg8));
  stage_idecode_rle #(.COUNT_WIDTH(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2), .o_dbg_state(dbg2));

  int act_sel = 0;
  logic [7:0] drv_byte = 8'h00;
  logic drv_valid = 1'b0;
  logic auto_ack = 1'b1;
  logic mon_ack;
  logic man_ack = 1'b0;
  logic w_ack_in;
  logic drv_done;

  assign w_ack_in       = auto_ack ? mon_ack : man_ack;
  assign bus8.opcode_in = drv_byte;
  assign bus2.opcode_in = drv_byte;
  assign bus8.drdy_in   = drv_valid && (act_sel == 0);
  assign bus2.drdy_in   = drv_valid && (act_sel == 1);
  assign bus8.ack_in    = w_ack_in && (act_sel == 0);
  assign bus2.ack_in    = w_ack_in && (act_sel == 1);

  int n_checks = 0;
  int n_pass = 0;
  int ack_cnt = 0;
  int unstable = 0;
  int max_seen = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic [7:0] stim_q[$];
  string cmds = "><+-.,[]";

  function automatic logic get_ack(input int sel);
    return (sel == 0) ? bus8.ack : bus2.ack;
  endfunction
  function automatic logic get_drdy(input int sel);
    return (sel == 0) ? bus8.drdy : bus2.drdy;
  endfunction
  function automatic logic [7:0] get_op(input int sel);
    return (sel == 0) ? bus8.operation : bus2.operation;
  endfunction
  function automatic logic [7:0] get_cnt(input int sel);
    return (sel == 0) ? bus8.count : {6'd0, bus2.count};
  endfunction

  // reference model: group the command stream into emissions
  function automatic int cmd_index(input logic [7:0] b);
    for (int i = 0; i < 8; i++) if (b == cmds[i]) return i;
    return -1;
  endfunction

  function automatic logic [15:0] pack(input int k, input int n);
    return {8'(1 << k), 8'(n)};
  endfunction

  task automatic model_push(input int max_cnt);
    int run_k;
    int run_n;
    int k;
    run_k = -1;
    run_n = 0;
    foreach (stim_q[i]) begin
      k = cmd_index(stim_q[i]);
      if (k < 0) continue;
      if (COALESCE && k < 4) begin
        if (k == run_k && run_n < max_cnt) begin
          run_n++;
        end else begin
          if (run_k >= 0) exp_q.push_back(pack(run_k, run_n));
          run_k = k;
          run_n = 1;
        end
      end else begin
        if (run_k >= 0) exp_q.push_back(pack(run_k, run_n));
        run_k = -1;
        exp_q.push_back(pack(k, 1));
      end
    end
    if (run_k >= 0) exp_q.push_back(pack(run_k, run_n));
  endtask

  task automatic load_str(input string s);
    stim_q.delete();
    for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
  endtask

  // driver: present each byte back-to-back and advance on ack
  task automatic drive_stream();
    int w;
    foreach (stim_q[i]) begin
      drv_byte = stim_q[i];
      drv_valid = 1'b1;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!get_ack(act_sel) && w < 200);
      if (!get_ack(act_sel)) begin
        n_checks++;
        $display("FAIL drive_ack_timeout: byte %h not acked after %0d cycles", stim_q[i], w);
        break;
      end
    end
    drv_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    int quiet;
    w = 0;
    quiet = 0;
    while (quiet < 4 && w < 300) begin
      @(negedge clk);
      w++;
      if (!get_drdy(act_sel) && !get_ack(act_sel)) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) begin
      n_checks++;
      $display("FAIL drain_timeout: outputs still active after %0d cycles", w);
    end
  endtask

  // execute-side monitor: records each emission and accepts it after a random hold
  initial begin : monitor
    logic seen;
    int hold;
    logic [15:0] cur;
    logic [15:0] now;
    seen = 1'b0;
    hold = 0;
    cur = '0;
    mon_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (get_ack(act_sel)) ack_cnt++;
      now = {get_op(act_sel), get_cnt(act_sel)};
      if (reset || !auto_ack || !get_drdy(act_sel)) begin
        seen = 1'b0;
        mon_ack = 1'b0;
      end else begin
        if (!seen) begin
          seen = 1'b1;
          cur = now;
          obs_q.push_back(now);
          hold = $urandom_range(0, 3);
          if (int'(now[7:0]) > max_seen) max_seen = int'(now[7:0]);
        end else if (now != cur) begin
          unstable++;
        end
        if (hold == 0) mon_ack = 1'b1;
        else begin
          hold--;
          mon_ack = 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus8.operation, bus8.count, bus8.drdy, bus8.ack} !== 18'd0)
      $display("FAIL reset_outputs8: got op=%h cnt=%0d drdy=%b ack=%b, expected all 0", bus8.operation, bus8.count, bus8.drdy, bus8.ack);
    else n_pass++;
    n_checks++;
    if ({bus2.operation, bus2.count, bus2.drdy, bus2.ack} !== 12'd0)
      $display("FAIL reset_outputs2: got op=%h cnt=%0d drdy=%b ack=%b, expected all 0", bus2.operation, bus2.count, bus2.drdy, bus2.ack);
    else n_pass++;
    n_checks++;
    if (dbg8 !== 2'd0 || dbg2 !== 2'd0) $display("FAIL reset_state: got %0d/%0d, expected 0/0 (IDLE)", dbg8, dbg2);
    else n_pass++;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus8.drdy !== 1'b0 || bus8.ack !== 1'b0) $display("FAIL idle_quiet: got drdy=%b ack=%b, expected 0 0", bus8.drdy, bus8.ack);
    else n_pass++;
  endtask

  task automatic test_run_flush();
    int a0;
    act_sel = 0;
    a0 = ack_cnt;
    load_str("+++>");
    model_push(255);
    drive_stream();
    drain();
    n_checks++;
    if (ack_cnt - a0 != 4) $display("FAIL run_flush_acks: got %0d ack pulses, expected 4", ack_cnt - a0);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL run_flush_len: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL run_flush_out%0d: got op=%h cnt=%0d, expected op=%h cnt=%0d", i, obs_q[i][15:8], obs_q[i][7:0], exp_q[i][15:8], exp_q[i][7:0]);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_comments();
    int a0;
    act_sel = 0;
    a0 = ack_cnt;
    load_str("+a+ b-");
    model_push(255);
    drive_stream();
    drain();
    n_checks++;
    if (ack_cnt - a0 != 6) $display("FAIL comments_acks: got %0d ack pulses, expected 6", ack_cnt - a0);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL comments_len: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL comments_out%0d: got op=%h cnt=%0d, expected op=%h cnt=%0d", i, obs_q[i][15:8], obs_q[i][7:0], exp_q[i][15:8], exp_q[i][7:0]);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_saturate();
    act_sel = 1;
    max_seen = 0;
    load_str("<<<<<<<");
    model_push(3);
    drive_stream();
    drain();
    n_checks++;
    if (max_seen > 3) $display("FAIL saturate_max: got count %0d, expected at most 3", max_seen);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL saturate_len: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL saturate_out%0d: got op=%h cnt=%0d, expected op=%h cnt=%0d", i, obs_q[i][15:8], obs_q[i][7:0], exp_q[i][15:8], exp_q[i][7:0]);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
    act_sel = 0;
  endtask

  task automatic test_hold();
    logic [7:0] exp_ops[3];
    int w;
    logic stable;
    logic no_ack;
    exp_ops[0] = 8'h40;
    exp_ops[1] = 8'h10;
    exp_ops[2] = 8'h80;
    act_sel = 0;
    auto_ack = 1'b0;
    man_ack = 1'b0;
    drv_done = 1'b0;
    load_str("[.]");
    fork
      begin
        drive_stream();
        drv_done = 1'b1;
      end
    join_none
    for (int j = 0; j < 3; j++) begin
      w = 0;
      @(negedge clk);
      while (!bus8.drdy && w < 50) begin
        @(negedge clk);
        w++;
      end
      n_checks++;
      if (bus8.operation !== exp_ops[j] || bus8.count !== 8'd1)
        $display("FAIL hold_out%0d: got op=%h cnt=%0d, expected op=%h cnt=1", j, bus8.operation, bus8.count, exp_ops[j]);
      else n_pass++;
      n_checks++;
      if (bus8.ack !== 1'b1 || bus8.drdy !== 1'b1) $display("FAIL hold_latency%0d: got ack=%b drdy=%b, expected 1 1", j, bus8.ack, bus8.drdy);
      else n_pass++;
      stable = 1'b1;
      no_ack = 1'b1;
      repeat (5) begin
        @(negedge clk);
        if (bus8.drdy !== 1'b1 || bus8.operation !== exp_ops[j] || bus8.count !== 8'd1) stable = 1'b0;
        if (bus8.ack !== 1'b0) no_ack = 1'b0;
      end
      n_checks++;
      if (stable !== 1'b1) $display("FAIL hold_stable%0d: got drdy=%b op=%h cnt=%0d, expected held op=%h", j, bus8.drdy, bus8.operation, bus8.count, exp_ops[j]);
      else n_pass++;
      n_checks++;
      if (no_ack !== 1'b1) $display("FAIL hold_no_ack%0d: got ack pulse during EMIT, expected none", j);
      else n_pass++;
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      n_checks++;
      if (bus8.drdy !== 1'b0 || bus8.operation !== 8'd0 || bus8.count !== 8'd0)
        $display("FAIL hold_release%0d: got drdy=%b op=%h cnt=%0d, expected 0 0 0", j, bus8.drdy, bus8.operation, bus8.count);
      else n_pass++;
    end
    w = 0;
    while (!drv_done && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (!drv_done) $display("FAIL hold_driver_done: got driver still busy, expected done");
    else n_pass++;
    auto_ack = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid_run();
    act_sel = 0;
    load_str("++");
    drive_stream();
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus8.operation, bus8.count, bus8.drdy, bus8.ack} !== 18'd0)
      $display("FAIL midrun_reset: got op=%h cnt=%0d drdy=%b ack=%b, expected all 0", bus8.operation, bus8.count, bus8.drdy, bus8.ack);
    else n_pass++;
    n_checks++;
    if (dbg8 !== 2'd0) $display("FAIL midrun_state: got %0d, expected 0 (IDLE)", dbg8);
    else n_pass++;
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
    @(negedge clk);
    load_str("-");
    model_push(255);
    drive_stream();
    drain();
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL midrun_len: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL midrun_out%0d: got op=%h cnt=%0d, expected op=%h cnt=%0d", i, obs_q[i][15:8], obs_q[i][7:0], exp_q[i][15:8], exp_q[i][7:0]);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    act_sel = 0;
    load_str("++");
    model_push(255);
    load_str("..,,[]");
    model_push(255);
    load_str("++..,,[]");
    drive_stream();
    drain();
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL b2b_len: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_out%0d: got op=%h cnt=%0d, expected op=%h cnt=%0d", i, obs_q[i][15:8], obs_q[i][7:0], exp_q[i][15:8], exp_q[i][7:0]);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    string pool;
    int n;
    int a0;
    logic [7:0] prev;
    pool = "+++--><<>.,[]a #";
    unstable = 0;
    for (int seg = 0; seg < 12; seg++) begin
      act_sel = seg % 2;
      stim_q.delete();
      n = $urandom_range(1, 16);
      prev = "+";
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 0) prev = pool[$urandom_range(0, pool.len() - 1)];
        stim_q.push_back(prev);
      end
      model_push((act_sel == 0) ? 255 : 3);
      a0 = ack_cnt;
      drive_stream();
      drain();
      n_checks++;
      if (ack_cnt - a0 != n) $display("FAIL random_acks%0d: got %0d ack pulses, expected %0d", seg, ack_cnt - a0, n);
      else n_pass++;
    end
    act_sel = 0;
    n_checks++;
    if (unstable != 0) $display("FAIL random_stable: got %0d output changes while held, expected 0", unstable);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL random_len: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL random_out%0d: got op=%h cnt=%0d, expected op=%h cnt=%0d", i, obs_q[i][15:8], obs_q[i][7:0], exp_q[i][15:8], exp_q[i][7:0]);
      else n_pass++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_run_flush();
    test_comments();
    test_saturate();
    test_hold();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
